ex_mem_pipe_reg: RTL and testbench

Parametrised EX/MEM pipeline register for the RISC-V pipeline. It carries execute-stage results and memory/write-back control to the memory stage through a configurable number of register stages. Unlike the previous single-stage register it adds synchronous reset, a per-stage valid bit, and flush/bubble insertion that zeroes side-effecting control. It also provides a saturating stall-cycle counter for performance monitoring. It sits between the ALU/branch unit and the data-memory interface; BUSY_WAIT comes from the data cache.

---
 rtl/ex_mem_pipe_reg.sv | 107 ++++++++++
 tb/tb_ex_mem_pipe_reg.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register: DEPTH register stages, DEPTH-edge latency, one entry per cycle.
// BUSY_WAIT freezes every stage; FLUSH and bubbles strip side-effecting control, payload rides along.
module ex_mem_pipe_reg #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 5,
    parameter int DEPTH       = 1,
    parameter int COUNT_WIDTH = 16
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   BUSY_WAIT,
    input  logic                   FLUSH,
    input  logic                   VALID_IN,
    input  logic                   REG_WRITE,
    input  logic                   BRANCH_RES,
    input  logic [2:0]             MEM_READ,
    input  logic [2:0]             MEM_WRITE,
    input  logic [1:0]             MEM_TO_REG,
    input  logic [ADDR_WIDTH-1:0]  IN_ADDRESS,
    input  logic [DATA_WIDTH-1:0]  ALU_RESULT,
    input  logic [DATA_WIDTH-1:0]  OUT2,
    input  logic [DATA_WIDTH-1:0]  PC_NEXT,
    output logic                   VALID_OUT,
    output logic                   REG_WRITE_OUT,
    output logic                   BRANCH_RES_OUT,
    output logic [2:0]             MEM_READ_OUT,
    output logic [2:0]             MEM_WRITE_OUT,
    output logic [1:0]             MEM_TO_REG_OUT,
    output logic [ADDR_WIDTH-1:0]  IN_ADDRESS_OUT,
    output logic [DATA_WIDTH-1:0]  ALU_RESULT_OUT,
    output logic [DATA_WIDTH-1:0]  OUT2_OUT,
    output logic [DATA_WIDTH-1:0]  PC_NEXT_OUT,
    output logic [COUNT_WIDTH-1:0] STALL_COUNT
);

    typedef struct packed {
        logic                  vld;
        logic                  reg_write;
        logic                  branch_res;
        logic [2:0]            mem_read;
        logic [2:0]            mem_write;
        logic [1:0]            mem_to_reg;
        logic [ADDR_WIDTH-1:0] dst_addr;
        logic [DATA_WIDTH-1:0] alu_result;
        logic [DATA_WIDTH-1:0] out2;
        logic [DATA_WIDTH-1:0] pc_next;
    } stage_t;

    stage_t                 stg [DEPTH];
    stage_t                 in_entry;
    logic [COUNT_WIDTH-1:0] stall_cnt;

    // A bubble keeps its payload but can never cause a write, read or branch downstream.
    always_comb begin
        in_entry            = '0;
        in_entry.vld        = VALID_IN;
        in_entry.reg_write  = VALID_IN & REG_WRITE;
        in_entry.branch_res = VALID_IN & BRANCH_RES;
        in_entry.mem_read   = VALID_IN ? MEM_READ  : 3'b000;
        in_entry.mem_write  = VALID_IN ? MEM_WRITE : 3'b000;
        in_entry.mem_to_reg = MEM_TO_REG;
        in_entry.dst_addr   = IN_ADDRESS;
        in_entry.alu_result = ALU_RESULT;
        in_entry.out2       = OUT2;
        in_entry.pc_next    = PC_NEXT;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                stg[i] <= '0;
            end
            stall_cnt <= '0;
        end else begin
            if (BUSY_WAIT && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + COUNT_WIDTH'(1);
            end
            if (FLUSH) begin
                for (int i = 0; i < DEPTH; i++) begin
                    stg[i].vld        <= 1'b0;
                    stg[i].reg_write  <= 1'b0;
                    stg[i].branch_res <= 1'b0;
                    stg[i].mem_read   <= 3'b000;
                    stg[i].mem_write  <= 3'b000;
                end
            end else if (!BUSY_WAIT) begin
                stg[0] <= in_entry;
                for (int i = 1; i < DEPTH; i++) begin
                    stg[i] <= stg[i-1];
                end
            end
        end
    end

    assign VALID_OUT      = stg[DEPTH-1].vld;
    assign REG_WRITE_OUT  = stg[DEPTH-1].reg_write;
    assign BRANCH_RES_OUT = stg[DEPTH-1].branch_res;
    assign MEM_READ_OUT   = stg[DEPTH-1].mem_read;
    assign MEM_WRITE_OUT  = stg[DEPTH-1].mem_write;
    assign MEM_TO_REG_OUT = stg[DEPTH-1].mem_to_reg;
    assign IN_ADDRESS_OUT = stg[DEPTH-1].dst_addr;
    assign ALU_RESULT_OUT = stg[DEPTH-1].alu_result;
    assign OUT2_OUT       = stg[DEPTH-1].out2;
    assign PC_NEXT_OUT    = stg[DEPTH-1].pc_next;
    assign STALL_COUNT    = stall_cnt;

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Bench for ex_mem_pipe_reg: four instances (DEPTH 1/2/3 and a 4-bit counter) share one input set.
module tb_ex_mem_pipe_reg;

    typedef struct packed {
        logic        vld;
        logic        rw;
        logic        br;
        logic [2:0]  mr;
        logic [2:0]  mw;
        logic [1:0]  mtr;
        logic [4:0]  addr;
        logic [31:0] alu;
        logic [31:0] out2;
        logic [31:0] pc;
    } out_t;

    typedef struct packed {
        logic        rst;
        logic        busy;
        logic        flush;
        logic        vin;
        logic        rw;
        logic        br;
        logic [2:0]  mr;
        logic [2:0]  mw;
        logic [1:0]  mtr;
        logic [4:0]  addr;
        logic [31:0] alu;
        logic [31:0] out2;
        logic [31:0] pc;
        out_t        e;
        logic [15:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst, busy, flush, vin, rw, br;
    logic [2:0]  mr, mw;
    logic [1:0]  mtr;
    logic [4:0]  addr;
    logic [31:0] alu, out2, pc;

    out_t        o1, o2, o3, o4;
    logic [15:0] c1, c2, c3;
    logic [3:0]  c4;

    int checks   = 0;
    int failures = 0;

    vec_t vecs [13];

    always #5 clk = ~clk;

    ex_mem_pipe_reg #(.DEPTH(1)) d1 (
        .CLK(clk), .RESET(rst), .BUSY_WAIT(busy), .FLUSH(flush), .VALID_IN(vin),
        .REG_WRITE(rw), .BRANCH_RES(br), .MEM_READ(mr), .MEM_WRITE(mw), .MEM_TO_REG(mtr),
        .IN_ADDRESS(addr), .ALU_RESULT(alu), .OUT2(out2), .PC_NEXT(pc),
        .VALID_OUT(o1.vld), .REG_WRITE_OUT(o1.rw), .BRANCH_RES_OUT(o1.br),
        .MEM_READ_OUT(o1.mr), .MEM_WRITE_OUT(o1.mw), .MEM_TO_REG_OUT(o1.mtr),
        .IN_ADDRESS_OUT(o1.addr), .ALU_RESULT_OUT(o1.alu), .OUT2_OUT(o1.out2),
        .PC_NEXT_OUT(o1.pc), .STALL_COUNT(c1)
    );

    ex_mem_pipe_reg #(.DEPTH(2)) d2 (
        .CLK(clk), .RESET(rst), .BUSY_WAIT(busy), .FLUSH(flush), .VALID_IN(vin),
        .REG_WRITE(rw), .BRANCH_RES(br), .MEM_READ(mr), .MEM_WRITE(mw), .MEM_TO_REG(mtr),
        .IN_ADDRESS(addr), .ALU_RESULT(alu), .OUT2(out2), .PC_NEXT(pc),
        .VALID_OUT(o2.vld), .REG_WRITE_OUT(o2.rw), .BRANCH_RES_OUT(o2.br),
        .MEM_READ_OUT(o2.mr), .MEM_WRITE_OUT(o2.mw), .MEM_TO_REG_OUT(o2.mtr),
        .IN_ADDRESS_OUT(o2.addr), .ALU_RESULT_OUT(o2.alu), .OUT2_OUT(o2.out2),
        .PC_NEXT_OUT(o2.pc), .STALL_COUNT(c2)
    );

    ex_mem_pipe_reg #(.DEPTH(3)) d3 (
        .CLK(clk), .RESET(rst), .BUSY_WAIT(busy), .FLUSH(flush), .VALID_IN(vin),
        .REG_WRITE(rw), .BRANCH_RES(br), .MEM_READ(mr), .MEM_WRITE(mw), .MEM_TO_REG(mtr),
        .IN_ADDRESS(addr), .ALU_RESULT(alu), .OUT2(out2), .PC_NEXT(pc),
        .VALID_OUT(o3.vld), .REG_WRITE_OUT(o3.rw), .BRANCH_RES_OUT(o3.br),
        .MEM_READ_OUT(o3.mr), .MEM_WRITE_OUT(o3.mw), .MEM_TO_REG_OUT(o3.mtr),
        .IN_ADDRESS_OUT(o3.addr), .ALU_RESULT_OUT(o3.alu), .OUT2_OUT(o3.out2),
        .PC_NEXT_OUT(o3.pc), .STALL_COUNT(c3)
    );

    ex_mem_pipe_reg #(.DEPTH(1), .COUNT_WIDTH(4)) d4 (
        .CLK(clk), .RESET(rst), .BUSY_WAIT(busy), .FLUSH(flush), .VALID_IN(vin),
        .REG_WRITE(rw), .BRANCH_RES(br), .MEM_READ(mr), .MEM_WRITE(mw), .MEM_TO_REG(mtr),
        .IN_ADDRESS(addr), .ALU_RESULT(alu), .OUT2(out2), .PC_NEXT(pc),
        .VALID_OUT(o4.vld), .REG_WRITE_OUT(o4.rw), .BRANCH_RES_OUT(o4.br),
        .MEM_READ_OUT(o4.mr), .MEM_WRITE_OUT(o4.mw), .MEM_TO_REG_OUT(o4.mtr),
        .IN_ADDRESS_OUT(o4.addr), .ALU_RESULT_OUT(o4.alu), .OUT2_OUT(o4.out2),
        .PC_NEXT_OUT(o4.pc), .STALL_COUNT(c4)
    );

    task automatic check_out(input string nm, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_val(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rst = 1'b0; busy = 1'b0; flush = 1'b0; vin = 1'b0; rw = 1'b0; br = 1'b0;
        mr = 3'h0; mw = 3'h0; mtr = 2'h0; addr = 5'h0; alu = 32'h0; out2 = 32'h0; pc = 32'h0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Drive one entry at the falling edge so it is captured by the next rising edge.
    task automatic drive(input logic v, input logic w, input logic [2:0] mwr, input logic [31:0] a,
                         input logic b, input logic f);
        @(negedge clk);
        vin = v; rw = w; mw = mwr; alu = a; busy = b; flush = f;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // {rst,busy,flush,vin,rw,br,mr,mw,mtr,addr,alu,out2,pc, expected{vld,rw,br,mr,mw,mtr,addr,alu,out2,pc}, cnt}
        vecs[0]  = '{1'b1,1'b1,1'b1,1'b1,1'b1,1'b1,3'h7,3'h7,2'h3,5'h1f,32'hFFFFFFFF,32'hFFFFFFFF,32'hFFFFFFFF,
                     '{1'b0,1'b0,1'b0,3'h0,3'h0,2'h0,5'h00,32'h0,32'h0,32'h0}, 16'd0};
        vecs[1]  = vecs[0];
        vecs[2]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,3'h0,3'h2,2'h1,5'h05,32'h12345678,32'h11,32'h104,
                     '{1'b1,1'b1,1'b0,3'h0,3'h2,2'h1,5'h05,32'h12345678,32'h11,32'h104}, 16'd0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,3'h4,3'h1,2'h2,5'h07,32'hAA,32'h22,32'h108,
                     '{1'b0,1'b0,1'b0,3'h0,3'h0,2'h2,5'h07,32'hAA,32'h22,32'h108}, 16'd0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b1,3'h1,3'h0,2'h0,5'h09,32'hBEEF,32'h33,32'h10C,
                     '{1'b1,1'b1,1'b1,3'h1,3'h0,2'h0,5'h09,32'hBEEF,32'h33,32'h10C}, 16'd0};
        vecs[5]  = '{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,3'h5,3'h5,2'h3,5'h01,32'h5555,32'h44,32'h110,
                     '{1'b1,1'b1,1'b1,3'h1,3'h0,2'h0,5'h09,32'hBEEF,32'h33,32'h10C}, 16'd1};
        vecs[6]  = vecs[5];
        vecs[6].e_cnt = 16'd2;
        vecs[7]  = '{1'b0,1'b1,1'b1,1'b1,1'b1,1'b1,3'h2,3'h2,2'h1,5'h02,32'h6666,32'h55,32'h114,
                     '{1'b0,1'b0,1'b0,3'h0,3'h0,2'h0,5'h09,32'hBEEF,32'h33,32'h10C}, 16'd3};
        vecs[8]  = '{1'b0,1'b0,1'b1,1'b1,1'b1,1'b0,3'h3,3'h3,2'h2,5'h03,32'h7777,32'h66,32'h118,
                     '{1'b0,1'b0,1'b0,3'h0,3'h0,2'h0,5'h09,32'hBEEF,32'h33,32'h10C}, 16'd3};
        vecs[9]  = '{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,3'h0,3'h2,2'h1,5'h0A,32'h1000,32'h77,32'h11C,
                     '{1'b1,1'b1,1'b0,3'h0,3'h2,2'h1,5'h0A,32'h1000,32'h77,32'h11C}, 16'd3};
        vecs[10] = '{1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,3'h0,3'h0,2'h0,5'h00,32'h0,32'h0,32'h0,
                     '{1'b0,1'b0,1'b0,3'h0,3'h0,2'h1,5'h0A,32'h1000,32'h77,32'h11C}, 16'd3};
        vecs[11] = '{1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,3'h7,3'h7,2'h3,5'h1f,32'h9999,32'h9,32'h9,
                     '{1'b0,1'b0,1'b0,3'h0,3'h0,2'h0,5'h00,32'h0,32'h0,32'h0}, 16'd0};
        vecs[12] = '{1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,3'h0,3'h0,2'h0,5'h00,32'h77,32'h0,32'h0,
                     '{1'b1,1'b0,1'b0,3'h0,3'h0,2'h0,5'h00,32'h77,32'h0,32'h0}, 16'd0};

        idle_inputs();

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            rst = vecs[i].rst; busy = vecs[i].busy; flush = vecs[i].flush; vin = vecs[i].vin;
            rw = vecs[i].rw; br = vecs[i].br; mr = vecs[i].mr; mw = vecs[i].mw; mtr = vecs[i].mtr;
            addr = vecs[i].addr; alu = vecs[i].alu; out2 = vecs[i].out2; pc = vecs[i].pc;
            @(posedge clk);
            #1;
            check_out($sformatf("vec%0d_out", i), o1, vecs[i].e);
            check_val($sformatf("vec%0d_cnt", i), 32'(c1), 32'(vecs[i].e_cnt));
        end

        // DEPTH=3 streaming: value k captured on edge k, visible after edge k+2.
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            if (k <= 4) drive(1'b1, 1'b0, 3'h0, 32'(k), 1'b0, 1'b0);
            else        drive(1'b0, 1'b0, 3'h0, 32'h0, 1'b0, 1'b0);
            if (k >= 3) begin
                check_val($sformatf("pipe3_alu_e%0d", k), o3.alu, 32'(k - 2));
                check_val($sformatf("pipe3_vld_e%0d", k), 32'(o3.vld), 32'd1);
            end else begin
                check_val($sformatf("pipe3_vld_e%0d", k), 32'(o3.vld), 32'd0);
            end
        end

        // DEPTH=2 stall: A at the output, B behind it, five held edges.
        do_reset();
        drive(1'b1, 1'b0, 3'h0, 32'hA0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 3'h0, 32'hB0, 1'b0, 1'b0);
        check_val("stall_a_before", o2.alu, 32'hA0);
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 1'b0, 3'h0, 32'hC0, 1'b1, 1'b0);
            check_val($sformatf("stall_hold%0d", k), o2.alu, 32'hA0);
        end
        check_val("stall_count5", 32'(c2), 32'd5);
        drive(1'b0, 1'b0, 3'h0, 32'h0, 1'b0, 1'b0);
        check_val("stall_release_b", o2.alu, 32'hB0);
        check_val("stall_release_vld", 32'(o2.vld), 32'd1);
        drive(1'b0, 1'b0, 3'h0, 32'h0, 1'b0, 1'b0);
        check_val("stall_no_dup_vld", 32'(o2.vld), 32'd0);

        // DEPTH=2 flush with stall: both in-flight writes lose their side effects.
        do_reset();
        drive(1'b1, 1'b1, 3'h2, 32'hE1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 3'h2, 32'hE2, 1'b0, 1'b0);
        check_out("flush_before", o2, '{1'b1,1'b1,1'b0,3'h0,3'h2,2'h0,5'h00,32'hE1,32'h0,32'h0});
        drive(1'b1, 1'b1, 3'h2, 32'hE3, 1'b1, 1'b1);
        check_out("flush_last", o2, '{1'b0,1'b0,1'b0,3'h0,3'h0,2'h0,5'h00,32'hE1,32'h0,32'h0});
        drive(1'b0, 1'b0, 3'h0, 32'h0, 1'b0, 1'b0);
        check_out("flush_stage0", o2, '{1'b0,1'b0,1'b0,3'h0,3'h0,2'h0,5'h00,32'hE2,32'h0,32'h0});

        // 4-bit counter saturation against the 16-bit counter.
        do_reset();
        for (int k = 0; k < 14; k++) drive(1'b0, 1'b0, 3'h0, 32'h0, 1'b1, 1'b0);
        check_val("sat_cnt14", 32'(c4), 32'hE);
        for (int k = 0; k < 6; k++) begin
            drive(1'b0, 1'b0, 3'h0, 32'h0, 1'b1, 1'b0);
            check_val($sformatf("sat_hold%0d", k), 32'(c4), 32'hF);
        end
        check_val("wide_cnt20", 32'(c1), 32'd20);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_val("sat_reset_clear", 32'(c4), 32'h0);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
